mem_request_arbiter: RTL and testbench
======================================

// Module: mem_request_arbiter
// PURPOSE
// - Shares the single cache/DRAM Memory port (grant_line/address in, done/done_address out) among N_REQ address-trace requesters.
// - Round-robin pick; one outstanding access at a time; waits for the matching done, then acks the requester.
// - Sits between trace sources (one per core/stream) and Memory inside top; all-ones address marks end-of-trace.
// PARAMETERS
// - N_REQ     2             number of requesters
// - ADDR_W    32            address width
// - TIMEOUT   1024          max cycles in WAIT before abort; must exceed worst DRAM miss latency
// - CNT_W     21            width of per-requester served counters (matches Memory counter)
// - SENTINEL  32'hFFFFFFFF  end-of-trace address
// PORTS
// - clk               in   1             clock, rising edge
// - rst_n             in   1             reset, asynchronous, active-low
// - req               in   N_REQ         per-requester request; held high with stable addr until ack
// - req_addr          in   N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
// - req_ack           out  N_REQ         one-cycle completion pulse to the served requester
// - ack_err           out  1             valid with req_ack; 1 = transaction aborted by timeout
// - mem_grant         out  1             drives Memory grant_line; one-cycle pulse per access
// - mem_address       out  ADDR_W        drives Memory address; stable from ISSUE until leaving WAIT
// - mem_done          in   1             Memory done
// - mem_done_address  in   ADDR_W        Memory done_address
// - all_done          out  1             every requester has delivered SENTINEL
// - timeout_err       out  1             sticky; set on any timeout, cleared only by reset
// - served_count      out  N_REQ*CNT_W   per-requester completed memory accesses, saturating
// BEHAVIOUR
// - Reset (async, rst_n=0): all outputs 0, state IDLE, rr pointer 0, finished mask 0, timer 0. Registered outputs only.
// - FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; sentinel path IDLE -> RESP.
// - IDLE: eligible = req & ~finished; none -> stay. Otherwise pick first eligible at or after pointer (wraps N_REQ-1 -> 0).
//   Latch index and address. Address == SENTINEL -> set finished[idx], go RESP with no memory access. Else -> ISSUE.
// - ISSUE: mem_grant=1 for exactly this cycle, mem_address = latched addr; timer cleared; -> WAIT.
// - WAIT: timer++ each cycle. mem_done=1 and mem_done_address==latched addr -> RESP, ack_err=0.
//   done with mismatched address is ignored. Timer reaches TIMEOUT-1 -> RESP, ack_err=1, timeout_err set.
// - RESP: req_ack[idx]=1 for this cycle only. served_count[idx]++ (saturates at 2^CNT_W-1) unless sentinel or timeout.
//   Pointer = idx+1 mod N_REQ; -> IDLE.
// - mem_done in IDLE/ISSUE/RESP ignored (covers stale done after reset).
// - Latency: req seen in IDLE cycle 0, grant cycle 1, done seen cycle k>=2, ack cycle k+1. Sentinel ack at cycle 1.
// - Requester dropping req before ack: transaction still completes, ack still pulses. New request is sampled no earlier than the IDLE after RESP.
// - finished requesters are never granted again, even if req stays high. all_done = &finished, registered.
// - Reset mid-transaction: mem_grant, req_ack and ack_err drop immediately. Pointer returns to 0. In-flight result is discarded.
// STRUCTURE
// - Shared include mem_ctrl_defs.vh holds the FSM state encodings (2-bit IDLE/ISSUE/WAIT/RESP) and SENTINEL. It is reused by top and the Memory controller.
// - Sub-module rr_pick: combinational round-robin selector (eligible, pointer -> one-hot grant + index). Its correctness is checked by a separate standalone unit test.
// - Timer width $clog2(TIMEOUT). Counters use generate loop per requester.
// TESTING
// - Single req0 addr 32'h4138, model done 10 cycles after grant -> mem_grant at cycle 1 only, ack[0] at cycle 12, served_count[0]=1, ack_err=0.
// - req0 and req1 held high continuously, model latency 3 -> grants alternate 0,1,0,1 starting with 0; no requester served twice in a row.
// - req0 addr 32'h2049, model returns done_address 32'h2048 then 32'h2049 -> first done ignored, ack only after the matching done.
// - TIMEOUT=16, model never responds -> ack[0] with ack_err=1 at cycle 18, timeout_err stays 1, served_count[0]=0.
// - req0 SENTINEL then req1 SENTINEL -> ack at cycle 1 with no mem_grant; req0 ignored afterwards; all_done=1 after second sentinel.
// - rst_n low during WAIT, late mem_done after release -> outputs 0 during reset; late done ignored; first grant after reset goes to req0.

Source files
------------

// File: rtl/mem_request_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_request_arbiter_pkg
// Brief   : Shared FSM encodings, sentinel address and sizing helper.
// Revision: 1.0 - initial release
// ============================================================================
package mem_request_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam logic [31:0] C_SENTINEL = 32'hFFFF_FFFF;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_request_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : mem_request_arbiter_rr_pick
// Brief   : Combinational round-robin selector: first eligible at or after pointer.
// Revision: 1.0 - initial release
// ============================================================================
module mem_request_arbiter_rr_pick
    import mem_request_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [IDX_W-1:0] pointer,
    output logic             valid,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] index
);

    always_comb begin
        int         cand;
        logic [IDX_W-1:0] cand_idx;
        cand     = 0;
        cand_idx = '0;
        valid    = 1'b0;
        grant    = '0;
        index    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(pointer) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!valid && eligible[cand_idx]) begin
                valid           = 1'b1;
                index           = cand_idx;
                grant[cand_idx] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_request_arbiter
// Brief   : Round-robin sharing of the single Memory port among trace requesters.
// Revision: 1.0 - initial release
// ============================================================================
module mem_request_arbiter
    import mem_request_arbiter_pkg::*;
#(
    parameter int                N_REQ    = 2,
    parameter int                ADDR_W   = 32,
    parameter int                TIMEOUT  = 1024,
    parameter int                CNT_W    = 21,
    parameter logic [ADDR_W-1:0] SENTINEL = ADDR_W'(C_SENTINEL)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        req_ack,
    output logic                    ack_err,
    output logic                    mem_grant,
    output logic [ADDR_W-1:0]       mem_address,
    input  logic                    mem_done,
    input  logic [ADDR_W-1:0]       mem_done_address,
    output logic                    all_done,
    output logic                    timeout_err,
    output logic [N_REQ*CNT_W-1:0]  served_count
);

    localparam int                 IDX_W      = idx_width(N_REQ);
    localparam int                 TIMER_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0]    finished_q, finished_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                mem_grant_q, mem_grant_d;
    logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
    logic [N_REQ-1:0]    req_ack_q, req_ack_d;
    logic                ack_err_q, ack_err_d;
    logic                timeout_err_q, timeout_err_d;
    logic                all_done_q, all_done_d;
    logic [N_REQ-1:0]    serve_inc;

    logic                pick_valid;
    logic [N_REQ-1:0]    pick_grant;
    logic [IDX_W-1:0]    pick_idx;
    logic [ADDR_W-1:0]   sel_addr;
    logic [N_REQ-1:0]    idx_onehot;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        return (int'(i) == N_REQ - 1) ? '0 : i + IDX_W'(1);
    endfunction

    mem_request_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .eligible (req & ~finished_q),
        .pointer  (ptr_q),
        .valid    (pick_valid),
        .grant    (pick_grant),
        .index    (pick_idx)
    );

    assign sel_addr   = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
    assign idx_onehot = N_REQ'(1) << idx_q;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        ptr_d         = ptr_q;
        finished_d    = finished_q;
        timer_d       = timer_q;
        mem_grant_d   = 1'b0;
        mem_address_d = mem_address_q;
        req_ack_d     = '0;
        ack_err_d     = 1'b0;
        timeout_err_d = timeout_err_q;
        serve_inc     = '0;
        // Outputs are computed for the state being entered so they appear registered in it.
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    idx_d = pick_idx;
                    if (sel_addr == SENTINEL) begin
                        finished_d = finished_q | pick_grant;
                        req_ack_d  = pick_grant;
                        ptr_d      = wrap_inc(pick_idx);
                        state_d    = ST_RESP;
                    end else begin
                        mem_address_d = sel_addr;
                        mem_grant_d   = 1'b1;
                        state_d       = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                timer_d = timer_q + TIMER_W'(1);
                if (mem_done && (mem_done_address == mem_address_q)) begin
                    req_ack_d = idx_onehot;
                    serve_inc = idx_onehot;
                    ptr_d     = wrap_inc(idx_q);
                    state_d   = ST_RESP;
                end else if (timer_q == TIMER_LAST) begin
                    req_ack_d     = idx_onehot;
                    ack_err_d     = 1'b1;
                    timeout_err_d = 1'b1;
                    ptr_d         = wrap_inc(idx_q);
                    state_d       = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        all_done_d = &finished_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            ptr_q         <= '0;
            finished_q    <= '0;
            timer_q       <= '0;
            mem_grant_q   <= 1'b0;
            mem_address_q <= '0;
            req_ack_q     <= '0;
            ack_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            all_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            ptr_q         <= ptr_d;
            finished_q    <= finished_d;
            timer_q       <= timer_d;
            mem_grant_q   <= mem_grant_d;
            mem_address_q <= mem_address_d;
            req_ack_q     <= req_ack_d;
            ack_err_q     <= ack_err_d;
            timeout_err_q <= timeout_err_d;
            all_done_q    <= all_done_d;
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (serve_inc[g] && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign served_count[g*CNT_W +: CNT_W] = cnt_q;
    end

    assign req_ack     = req_ack_q;
    assign ack_err     = ack_err_q;
    assign mem_grant   = mem_grant_q;
    assign mem_address = mem_address_q;
    assign all_done    = all_done_q;
    assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_request_arbiter
// Brief   : Directed vector table plus hand sequences for the request arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_request_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int TO = 16;
    localparam int CW = 21;
    localparam logic [31:0] SENT = 32'hFFFF_FFFF;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_ack;
    logic            ack_err;
    logic            mem_grant;
    logic [AW-1:0]   mem_address;
    logic            mem_done;
    logic [AW-1:0]   mem_done_address;
    logic            all_done;
    logic            timeout_err;
    logic [N*CW-1:0] served_count;

    logic            t_done, m_done, model_on;
    logic [AW-1:0]   t_daddr, m_daddr, lat_addr;
    int              model_lat;
    int              m_cnt;
    logic            m_pend;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign mem_done         = model_on ? m_done  : t_done;
    assign mem_done_address = model_on ? m_daddr : t_daddr;

    mem_request_arbiter #(
        .N_REQ    (N),
        .ADDR_W   (AW),
        .TIMEOUT  (TO),
        .CNT_W    (CW),
        .SENTINEL (SENT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req              (req),
        .req_addr         (req_addr),
        .req_ack          (req_ack),
        .ack_err          (ack_err),
        .mem_grant        (mem_grant),
        .mem_address      (mem_address),
        .mem_done         (mem_done),
        .mem_done_address (mem_done_address),
        .all_done         (all_done),
        .timeout_err      (timeout_err),
        .served_count     (served_count)
    );

    // Memory model: answers with the granted address model_lat cycles after the grant.
    initial begin
        m_done   = 1'b0;
        m_daddr  = '0;
        lat_addr = '0;
        m_pend   = 1'b0;
        m_cnt    = 0;
        forever begin
            @(negedge clk);
            m_done = 1'b0;
            if (m_pend) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_done  = 1'b1;
                    m_daddr = lat_addr;
                    m_pend  = 1'b0;
                end
            end else if (model_on && mem_grant) begin
                m_pend   = 1'b1;
                m_cnt    = model_lat;
                lat_addr = mem_address;
            end
        end
    end

    typedef struct {
        logic [1:0]  req;
        logic [31:0] a0;
        logic        done;
        logic [31:0] daddr;
        logic        exp_grant;
        logic [1:0]  exp_ack;
        logic        exp_err;
        logic [31:0] exp_maddr;
        logic [20:0] exp_cnt0;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        req      = '0;
        req_addr = '0;
        t_done   = 1'b0;
        t_daddr  = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int          ng, na, cyc;
        logic        got;
        logic [1:0]  seen_ack;
        logic        seen_grant;

        model_on  = 1'b0;
        model_lat = 3;

        // single access (done 10 cycles after grant) then mismatched-then-matching done
        tbl[0] = '{2'b01, 32'h4138, 1'b0, 32'h0,    1'b1, 2'b00, 1'b0, 32'h4138, 21'd0};
        for (int i = 1; i <= 10; i++) begin
            tbl[i] = '{2'b01, 32'h4138, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 32'h4138, 21'd0};
        end
        tbl[11] = '{2'b01, 32'h4138, 1'b1, 32'h4138, 1'b0, 2'b01, 1'b0, 32'h4138, 21'd1};
        tbl[12] = '{2'b00, 32'h4138, 1'b0, 32'h0,    1'b0, 2'b00, 1'b0, 32'h4138, 21'd1};
        tbl[13] = '{2'b01, 32'h2049, 1'b0, 32'h0,    1'b1, 2'b00, 1'b0, 32'h2049, 21'd1};
        tbl[14] = '{2'b01, 32'h2049, 1'b0, 32'h0,    1'b0, 2'b00, 1'b0, 32'h2049, 21'd1};
        tbl[15] = '{2'b01, 32'h2049, 1'b1, 32'h2048, 1'b0, 2'b00, 1'b0, 32'h2049, 21'd1};
        tbl[16] = '{2'b01, 32'h2049, 1'b1, 32'h2049, 1'b0, 2'b01, 1'b0, 32'h2049, 21'd2};
        tbl[17] = '{2'b00, 32'h2049, 1'b0, 32'h0,    1'b0, 2'b00, 1'b0, 32'h2049, 21'd2};

        rst_n    = 1'b0;
        req      = '0;
        req_addr = '0;
        t_done   = 1'b0;
        t_daddr  = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset mem_grant",    mem_grant,    0);
        chk("reset req_ack",      req_ack,      0);
        chk("reset ack_err",      ack_err,      0);
        chk("reset mem_address",  mem_address,  0);
        chk("reset all_done",     all_done,     0);
        chk("reset timeout_err",  timeout_err,  0);
        chk("reset served_count", served_count, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            req            = tbl[i].req;
            req_addr[31:0] = tbl[i].a0;
            t_done         = tbl[i].done;
            t_daddr        = tbl[i].daddr;
            tick();
            chk($sformatf("vec%0d mem_grant", i),   mem_grant,           tbl[i].exp_grant);
            chk($sformatf("vec%0d req_ack", i),     req_ack,             tbl[i].exp_ack);
            chk($sformatf("vec%0d ack_err", i),     ack_err,             tbl[i].exp_err);
            chk($sformatf("vec%0d mem_address", i), mem_address,         tbl[i].exp_maddr);
            chk($sformatf("vec%0d served0", i),     served_count[20:0],  tbl[i].exp_cnt0);
        end

        // round robin with both requesters held high
        do_reset();
        model_on  = 1'b1;
        model_lat = 3;
        req_addr  = {32'h0000_B000, 32'h0000_A000};
        req       = 2'b11;
        ng = 0; na = 0; cyc = 0;
        while (na < 6 && cyc < 200) begin
            tick();
            cyc++;
            if (mem_grant) begin
                chk($sformatf("rr grant%0d addr", ng), mem_address,
                    (ng % 2 == 0) ? 32'h0000_A000 : 32'h0000_B000);
                ng++;
                if (ng == 6) req = 2'b00;
            end
            if (req_ack != 2'b00) begin
                chk($sformatf("rr ack%0d", na), req_ack, (na % 2 == 0) ? 2'b01 : 2'b10);
                na++;
            end
        end
        chk("rr ack total", na, 6);
        chk("rr served", served_count, {21'd3, 21'd3});
        tick();
        model_on = 1'b0;

        // timeout: memory never answers
        do_reset();
        req_addr[31:0] = 32'h0000_7770;
        req            = 2'b01;
        got            = 1'b0;
        for (int c = 1; c <= 40 && !got; c++) begin
            tick();
            if (req_ack[0]) begin
                got = 1'b1;
                chk("timeout ack cycle", c, 18);
                chk("timeout ack_err", ack_err, 1);
                chk("timeout served0", served_count[20:0], 0);
            end
        end
        chk("timeout acked", got, 1);
        req = 2'b00;
        repeat (3) tick();
        chk("timeout_err sticky", timeout_err, 1);
        chk("ack_err cleared", ack_err, 0);
        chk("timeout served", served_count, 0);

        // reset during WAIT, stale done afterwards
        do_reset();
        req_addr = {32'h0000_5550, 32'h0000_3330};
        req      = 2'b01;
        tick();
        tick();
        t_done  = 1'b1;
        t_daddr = 32'h0000_3330;
        tick();
        chk("pre ack0", req_ack, 2'b01);
        t_done = 1'b0;
        req    = 2'b10;
        tick();
        tick();
        chk("pre grant1 addr", mem_address, 32'h0000_5550);
        tick();
        #2;
        rst_n = 1'b0;
        req   = 2'b00;
        #1;
        chk("mid rst mem_grant",   mem_grant,    0);
        chk("mid rst req_ack",     req_ack,      0);
        chk("mid rst ack_err",     ack_err,      0);
        chk("mid rst mem_address", mem_address,  0);
        chk("mid rst served",      served_count, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        t_done  = 1'b1;
        t_daddr = 32'h0000_5550;
        seen_ack   = 2'b00;
        seen_grant = 1'b0;
        tick();
        t_done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            seen_ack   = seen_ack | req_ack;
            seen_grant = seen_grant | mem_grant;
            tick();
        end
        chk("stale done ack", seen_ack, 0);
        chk("stale done grant", seen_grant, 0);
        req = 2'b11;
        tick();
        chk("post rst grant", mem_grant, 1);
        chk("post rst addr0", mem_address, 32'h0000_3330);
        tick();
        t_done  = 1'b1;
        t_daddr = 32'h0000_3330;
        tick();
        chk("post rst ack0", req_ack, 2'b01);
        t_done = 1'b0;
        req    = 2'b00;
        tick();
        chk("post rst served", served_count, {21'd0, 21'd1});

        // end-of-trace sentinels
        do_reset();
        req_addr = {32'h0000_0000, SENT};
        req      = 2'b01;
        tick();
        chk("sent0 ack", req_ack, 2'b01);
        chk("sent0 grant", mem_grant, 0);
        chk("sent0 all_done", all_done, 0);
        req_addr = {SENT, SENT};
        req      = 2'b11;
        tick();
        chk("sent resp ack", req_ack, 2'b00);
        tick();
        chk("sent1 ack", req_ack, 2'b10);
        chk("sent1 grant", mem_grant, 0);
        chk("sent1 all_done", all_done, 1);
        req_addr   = {SENT, 32'h0000_1000};
        seen_ack   = 2'b00;
        seen_grant = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            seen_ack   = seen_ack | req_ack;
            seen_grant = seen_grant | mem_grant;
        end
        chk("finished ack", seen_ack, 0);
        chk("finished grant", seen_grant, 0);
        chk("finished all_done", all_done, 1);
        chk("sentinel served", served_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
